// File: rtl/rip_mmu_port_arbiter.sv
// Round-robin arbiter funnelling N requesters onto MMU port 1.
// One transaction in flight; ISSUE/WAIT bounded by a timeout.
module rip_mmu_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024,
  localparam int BE = DATA_WIDTH / 8,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BE-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_dout,
  output logic                          resp_err,
  output logic [BE-1:0]                 mmu_we,
  output logic                          mmu_re,
  output logic [ADDR_WIDTH-1:0]         mmu_addr,
  output logic [DATA_WIDTH-1:0]         mmu_din,
  input  logic [DATA_WIDTH-1:0]         mmu_dout,
  input  logic                          mmu_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BE-1:0]         we_q, we_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  err_q, err_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;

  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  logic          issue;
  logic          expired;

  // Walk from farthest to nearest so the first index after last_q wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  assign expired = (cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    addr_d   = addr_q;
    we_d     = we_q;
    din_d    = din_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    err_d    = err_q;
    ready_d  = '0;
    rvalid_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          idx_d            = gnt_idx;
          addr_d           = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          we_d             = req_we[int'(gnt_idx)*BE +: BE];
          din_d            = req_din[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          ready_d[gnt_idx] = 1'b1;
          cnt_d            = '0;
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mmu_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if (expired) begin
          dout_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (!mmu_busy) begin
          dout_d  = mmu_dout;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (expired) begin
          dout_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        rvalid_d[idx_q] = 1'b1;
        last_d          = idx_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      addr_q   <= '0;
      we_q     <= '0;
      din_q    <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
      ready_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      din_q    <= din_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign issue      = (state_q == S_ISSUE);
  assign mmu_re     = issue && (we_q == '0);
  assign mmu_we     = issue ? we_q : '0;
  assign mmu_addr   = issue ? addr_q : '0;
  assign mmu_din    = issue ? din_q : '0;
  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_dout  = dout_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_rip_mmu_port_arbiter.sv
// Randomized bench for rip_mmu_port_arbiter against a transaction-level
// model: round-robin pick, MMU responder and expected latencies.
module tb_rip_mmu_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BE = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*BE-1:0] req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_din = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_dout;
  logic            resp_err;
  logic [BE-1:0]   mmu_we;
  logic            mmu_re;
  logic [AW-1:0]   mmu_addr;
  logic [DW-1:0]   mmu_din;
  logic [DW-1:0]   mmu_dout = '0;
  logic            mmu_busy = 1'b0;

  always #5 clk = ~clk;

  rip_mmu_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_din(req_din),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_dout(resp_dout), .resp_err(resp_err),
    .mmu_we(mmu_we), .mmu_re(mmu_re),
    .mmu_addr(mmu_addr), .mmu_din(mmu_din),
    .mmu_dout(mmu_dout), .mmu_busy(mmu_busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // requester side
  bit          p_valid[N];
  logic [BE-1:0] p_we[N];
  logic [AW-1:0] p_addr[N];
  logic [DW-1:0] p_din[N];
  bit          cont[N];
  bit          rnd_en = 0;

  // transaction model
  int  cyc = 0;
  int  last = N - 1;
  bit  busy_txn = 0;
  int  t_idx, t_cyc, ncmd;
  logic [BE-1:0] t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_din;
  int  grants[$];

  // MMU responder
  int  r_phase = 0, r_wait = 0, r_cnt = 0, r_d = 0, r_b = 1;
  bit  r_stuck = 0;
  logic [DW-1:0] r_data = '0;
  bit  f_en = 0, f_stuck = 0;
  int  f_d = 1, f_b = 1;
  logic [DW-1:0] f_data = '0;

  function automatic int rr_pick(logic [N-1:0] v, int l);
    for (int k = 1; k <= N; k++)
      if (v[(l + k) % N]) return (l + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = p_valid[i];
      req_we[i*BE +: BE]   = p_we[i];
      req_addr[i*AW +: AW] = p_addr[i];
      req_din[i*DW +: DW]  = p_din[i];
    end
  endtask

  task automatic set_req(int i, logic [BE-1:0] we,
                         logic [AW-1:0] a, logic [DW-1:0] d);
    p_valid[i] = 1;
    p_we[i]    = we;
    p_addr[i]  = a;
    p_din[i]   = d;
  endtask

  task automatic new_req(int i);
    logic [BE-1:0] we;
    we = ($urandom_range(1) == 1) ? BE'($urandom_range(1, 15)) : '0;
    set_req(i, we, $urandom, $urandom);
  endtask

  task automatic step();
    int g;
    @(negedge clk);
    cyc++;
    if (req_ready != '0) begin
      check("rdy_onehot", $countones(req_ready), 1);
      check("rdy_when_idle", busy_txn, 0);
      check("grant_idx", onehot_idx(req_ready), rr_pick(req_valid, last));
      g = onehot_idx(req_ready);
      grants.push_back(g);
      busy_txn = 1;
      t_idx = g; t_cyc = cyc; ncmd = 0;
      t_we = p_we[g]; t_addr = p_addr[g]; t_din = p_din[g];
      p_valid[g] = 0;
      if (f_en) begin
        r_stuck = f_stuck; r_d = f_d; r_b = f_b; r_data = f_data;
      end else begin
        r_stuck = ($urandom_range(7) == 0);
        r_d = $urandom_range(3);
        r_b = $urandom_range(1, 3);
        r_data = $urandom;
      end
      r_wait = 0;
    end
    if (mmu_re || mmu_we != '0) begin
      ncmd++;
      check("cmd_in_txn", busy_txn, 1);
      check("re_we_excl", mmu_re && (mmu_we != '0), 0);
      check("cmd_addr", mmu_addr, t_addr);
      check("cmd_we", mmu_we, t_we);
      check("cmd_re", mmu_re, t_we == '0);
      if (t_we != '0) check("cmd_din", mmu_din, t_din);
      if (r_phase == 0 && !r_stuck) begin
        if (r_wait == r_d) begin
          mmu_busy = 1; mmu_dout = r_data; r_cnt = r_b; r_phase = 1;
        end else r_wait++;
      end
    end else if (r_phase == 1) begin
      r_cnt--;
      if (r_cnt == 0) begin mmu_busy = 0; r_phase = 0; end
    end
    if (resp_valid != '0) begin
      check("resp_expected", busy_txn, 1);
      check("resp_onehot", $countones(resp_valid), 1);
      check("resp_idx", onehot_idx(resp_valid), t_idx);
      check("resp_lat", cyc - t_cyc, r_stuck ? TO + 1 : r_d + r_b + 2);
      check("cmd_cycles", ncmd, r_stuck ? TO : r_d + 1);
      check("resp_err", resp_err, r_stuck);
      if (r_stuck) check("resp_dout_to", resp_dout, 0);
      else if (t_we == '0) check("resp_dout", resp_dout, r_data);
      last = t_idx;
      busy_txn = 0;
    end else if (busy_txn && cyc - t_cyc > 40) begin
      check("resp_watchdog", cyc - t_cyc, 40);
      busy_txn = 0;
    end
    for (int i = 0; i < N; i++)
      if (!p_valid[i] && (cont[i] || (rnd_en && $urandom_range(3) == 0)))
        new_req(i);
    pack();
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++)
      if (p_valid[i]) return 1;
    return 0;
  endfunction

  task automatic drain();
    for (int k = 0; k < 300 && (busy_txn || any_pending()); k++) step();
    check("drained", busy_txn || any_pending(), 0);
  endtask

  task automatic check_outs_zero(string pfx);
    check({pfx, "_ready"}, req_ready, 0);
    check({pfx, "_rvalid"}, resp_valid, 0);
    check({pfx, "_dout"}, resp_dout, 0);
    check({pfx, "_err"}, resp_err, 0);
    check({pfx, "_mwe"}, mmu_we, 0);
    check({pfx, "_mre"}, mmu_re, 0);
    check({pfx, "_maddr"}, mmu_addr, 0);
    check({pfx, "_mdin"}, mmu_din, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      p_valid[i] = 0; p_we[i] = '0; p_addr[i] = '0; p_din[i] = '0; cont[i] = 0;
    end
    pack();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs_zero("rst");
    rstn = 1;

    // single read, busy one cycle after issue for one cycle
    f_en = 1; f_stuck = 0; f_d = 1; f_b = 1; f_data = 32'hDEADBEEF;
    set_req(0, '0, 32'h100, '0); pack();
    drain();

    // byte-masked write from requester 1
    f_data = 32'h0BAD0BAD;
    set_req(1, 4'b0011, 32'h204, 32'h1234); pack();
    drain();

    // contention between 0 and 1
    f_en = 0;
    grants.delete();
    cont[0] = 1; cont[1] = 1;
    for (int k = 0; k < 200 && grants.size() < 4; k++) step();
    check("cont_count", grants.size() >= 4, 1);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      check("cont_order", grants[k], k % 2);
    cont[0] = 0; cont[1] = 0;
    drain();

    // wrap: after a grant to 2, 0 beats 2
    set_req(2, '0, 32'h40, '0); pack();
    drain();
    grants.delete();
    set_req(0, '0, 32'h44, '0);
    set_req(2, '0, 32'h48, '0); pack();
    for (int k = 0; k < 50 && grants.size() == 0; k++) step();
    check("wrap_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    drain();

    // timeout with busy stuck low
    f_en = 1; f_stuck = 1;
    set_req(1, '0, 32'h300, '0); pack();
    drain();
    f_en = 0; f_stuck = 0;

    // random traffic
    rnd_en = 1;
    for (int k = 0; k < 600; k++) step();
    rnd_en = 0;
    drain();

    // reset while the MMU is busy
    set_req(1, '0, 32'h500, '0); pack();
    f_en = 1; f_d = 0; f_b = 3;
    for (int k = 0; k < 50 && r_phase != 1; k++) step();
    check("reach_wait", r_phase, 1);
    f_en = 0;
    @(negedge clk);
    rstn = 0;
    @(negedge clk);
    check_outs_zero("midrst");
    rstn = 1;
    mmu_busy = 0; r_phase = 0;
    busy_txn = 0; last = N - 1;
    grants.delete();
    set_req(0, '0, 32'h600, '0);
    set_req(2, '0, 32'h604, '0); pack();
    for (int k = 0; k < 50 && grants.size() == 0; k++) step();
    check("post_rst_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rip_mmu_port_arbiter.md
RIP_MMU_PORT_ARBITER -- requirements
Module: rip_mmu_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width BE = DATA_WIDTH/8.
REQ-004 The block SHALL have parameter TIMEOUT, default 1024, maximum cycles in any MMU-wait state.
REQ-005 The block SHALL have port clk  input  1  clock; all logic on posedge.
REQ-006 The block SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-007 The block SHALL have port req_valid  input  NUM_REQ  per-requester request pending.
REQ-008 The block SHALL have port req_we  input  NUM_REQ*BE  per-requester byte write enables; all-zero means read.
REQ-009 The block SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address.
REQ-010 The block SHALL have port req_din  input  NUM_REQ*DATA_WIDTH  per-requester write data.
REQ-011 The block SHALL have port req_ready  output  NUM_REQ  one-cycle accept pulse, one-hot.
REQ-012 The block SHALL have port resp_valid  output  NUM_REQ  one-cycle completion pulse, one-hot.
REQ-013 The block SHALL have port resp_dout  output  DATA_WIDTH  read data, valid while resp_valid is nonzero.
REQ-014 The block SHALL have port resp_err  output  1  timeout flag, valid with resp_valid.
REQ-015 The block SHALL have ports mmu_we (BE), mmu_re (1), mmu_addr (ADDR_WIDTH), mmu_din (DATA_WIDTH) as outputs, and mmu_dout (DATA_WIDTH), mmu_busy (1) as inputs: the MMU port-1 connection.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-017 In IDLE with any req_valid set, the block SHALL grant round-robin: first set index strictly after last_grant, wrapping modulo NUM_REQ.
REQ-018 On grant, the block SHALL in the same edge latch index, addr, we and din, pulse req_ready[index] for exactly one cycle, and enter ISSUE.
REQ-019 Requesters SHALL hold req_valid and fields stable until req_ready; after req_ready the fields are don't-care.
REQ-020 In ISSUE the block SHALL drive mmu_addr/mmu_din from the latch, with mmu_re=1 if latched we is zero, else mmu_we=latched we.
REQ-021 ISSUE SHALL hold the command until mmu_busy is sampled 1, then deassert mmu_re/mmu_we and enter WAIT.
REQ-022 WAIT SHALL remain until mmu_busy is sampled 0, then capture mmu_dout into resp_dout and enter RESP.
REQ-023 RESP SHALL pulse resp_valid[index] for one cycle, update last_grant to index, and return to IDLE; the next grant happens no earlier than the cycle after RESP.
REQ-024 Minimum latency, with busy rising the cycle after issue and falling one cycle later, SHALL be: req_ready at T, resp_valid at T+4.
REQ-025 Write transactions SHALL also complete with resp_valid; resp_dout is then don't-care.
REQ-026 A 16-bit wait counter SHALL clear on entry to ISSUE and to WAIT.
REQ-027 When the wait counter reaches TIMEOUT, the block SHALL drop the command, enter RESP with resp_err=1, and set resp_dout=0.
REQ-028 The block SHALL drive resp_err=0 on all non-timeout responses.
REQ-029 At most one transaction SHALL be outstanding; req_valid arriving outside IDLE only waits.
REQ-030 mmu_re and mmu_we SHALL never be nonzero simultaneously, and both SHALL be 0 outside ISSUE.
REQ-031 With a single requester continuously valid, it SHALL be granted on every IDLE visit; there is no starvation under round-robin.

Reset
REQ-032 While rstn=0 at a clock edge, the block SHALL enter state IDLE, set last_grant=NUM_REQ-1 so requester 0 has first priority, and clear the counter and latches.
REQ-033 During reset, all outputs SHALL be 0: req_ready, resp_valid, resp_dout, resp_err, mmu_we, mmu_re, mmu_addr, mmu_din.
REQ-034 Reset mid-transaction SHALL abort the transaction without issuing resp_valid; the command is dropped the next cycle.

Verification
REQ-035 The bench SHALL cover single read: req0 addr 0x100, MMU busy 1 cycle, dout 0xDEADBEEF -> req_ready[0] at T, mmu_re held until busy, resp_valid[0] with 0xDEADBEEF at T+4.
REQ-036 The bench SHALL cover a write: req1 we 4'b0011, addr 0x204, din 0x1234 -> mmu_we=4'b0011 with mmu_din=0x1234, mmu_re=0, resp_valid[1], resp_err=0.
REQ-037 The bench SHALL cover contention: req0 and req1 valid continuously after reset -> grant order 0,1,0,1 and never two consecutive grants to the same requester.
REQ-038 The bench SHALL cover timeout: TIMEOUT=8, mmu_busy stuck 0 -> command dropped after 8 ISSUE cycles, resp_valid with resp_err=1 and resp_dout=0.
REQ-039 The bench SHALL cover reset in WAIT: rstn low 1 cycle -> all outputs 0, no resp_valid, next request granted to requester 0.
REQ-040 The bench SHALL cover the wrap case: NUM_REQ=3, last_grant=2, req0 and req2 valid -> requester 0 granted.
